// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: one outstanding imem read feeding an in-order PC/instruction queue.
// Optional feature macro FETCH_ALIGN_CHECK_EN: misaligned redirects raise fetch_fault and halt fetch.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h00400000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [ADDR_W-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  output logic              fetch_fault
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN
`ifdef FETCH_ALIGN_CHECK_EN
    , S_HALT
`endif
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic [ADDR_W-1:0] req_pc_reg, req_pc_next;
  logic [ADDR_W-1:0] redirect_tgt;
  logic [CNT_W-1:0]  count_reg, count_next, count_after;
  logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
  logic [ADDR_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic              imem_req_reg, instr_valid_reg;
  logic              push, pop, flush, accept, pending;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_reg, fault_next, misaligned;
  assign redirect_tgt = redirect_pc;
  assign misaligned   = (redirect_pc[1:0] != 2'b00);
  assign fetch_fault  = fault_reg;
`else
  assign redirect_tgt = redirect_pc & {{(ADDR_W-2){1'b1}}, 2'b00};
  assign fetch_fault  = 1'b0;
`endif

  assign imem_req    = imem_req_reg;
  assign imem_addr   = fetch_pc_reg;
  assign instr_valid = instr_valid_reg;
  assign instr_data  = data_mem[rd_ptr_reg];
  assign instr_pc    = pc_mem[rd_ptr_reg];

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    req_pc_next   = req_pc_reg;
    push          = 1'b0;
    pop           = instr_valid_reg && instr_ready;
    flush         = 1'b0;
    pending       = 1'b0;
    accept        = (state_reg == S_REQ) && imem_ready;
    count_after   = count_reg + CNT_W'(1) - CNT_W'(pop);
`ifdef FETCH_ALIGN_CHECK_EN
    fault_next    = fault_reg;
`endif
    case (state_reg)
      S_IDLE: if (count_reg < DEPTH_C) state_next = S_REQ;
      S_REQ: begin
        if (imem_ready) begin
          req_pc_next   = fetch_pc_reg;
          fetch_pc_next = fetch_pc_reg + ADDR_W'(4);
          state_next    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          push       = 1'b1;
          state_next = (count_after < DEPTH_C) ? S_REQ : S_IDLE;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid) begin
`ifdef FETCH_ALIGN_CHECK_EN
          state_next = fault_reg ? S_HALT : S_REQ;
`else
          state_next = S_REQ;
`endif
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      S_HALT: state_next = S_HALT;
`endif
      default: state_next = S_IDLE;
    endcase

    // Redirect overrides everything; a read still owed by memory must be drained first.
    // A response landing in the same cycle settles the pending read, even from DRAIN.
    if (redirect_valid) begin
      flush         = 1'b1;
      push          = 1'b0;
      pop           = 1'b0;
      fetch_pc_next = redirect_tgt;
      pending       = accept ||
                      (((state_reg == S_WAIT) || (state_reg == S_DRAIN)) && !imem_rvalid);
`ifdef FETCH_ALIGN_CHECK_EN
      fault_next = misaligned;
      if (pending)         state_next = S_DRAIN;
      else if (misaligned) state_next = S_HALT;
      else                 state_next = S_REQ;
`else
      state_next = pending ? S_DRAIN : S_REQ;
`endif
    end

    count_next = flush ? '0 : (count_reg + CNT_W'(push) - CNT_W'(pop));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= S_IDLE;
      fetch_pc_reg    <= RESET_PC;
      req_pc_reg      <= '0;
      imem_req_reg    <= 1'b0;
      instr_valid_reg <= 1'b0;
      count_reg       <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_reg       <= 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else begin
      state_reg       <= state_next;
      fetch_pc_reg    <= fetch_pc_next;
      req_pc_reg      <= req_pc_next;
      imem_req_reg    <= (state_next == S_REQ);
      instr_valid_reg <= (count_next != '0);
      count_reg       <= count_next;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_reg       <= fault_next;
`endif
      if (flush) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
      end else begin
        if (push) begin
          data_mem[wr_ptr_reg] <= imem_rdata;
          pc_mem[wr_ptr_reg]   <= req_pc_reg;
          wr_ptr_reg           <= wr_ptr_reg + PTR_W'(1);
        end
        if (pop) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: sequential-PC reference model, randomized memory latency,
// stalls and redirects; a negedge monitor compares every consumed instruction.
module tb_instr_fetch_unit;
  localparam int          ADDR_W   = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h00400000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .fetch_fault(fetch_fault)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        arrived;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] exp_fetch_pc = RESET_PC;
  bit          mon_en = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  bit          mem_busy = 1'b0;
  bit          mem_live = 1'b0;
  int          mem_wait = 0;
  logic [31:0] mem_addr = '0;
  int          mem_lat_lo = 1;
  int          mem_lat_hi = 1;
  int          accepts = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_96E1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares each consumed instruction and tracks what the model expects next.
  always @(negedge clk) begin
    bit   exp_valid;
    exp_t e;
    if (mon_en && rst) begin
      exp_valid = (sb_q.size() != 0) && sb_q[0].arrived;
      check("instr_valid", {31'b0, instr_valid}, {31'b0, exp_valid});
      check("fetch_fault", {31'b0, fetch_fault}, 32'd0);
      if (prev_stall) begin
        check("req_hold", {31'b0, imem_req}, 32'd1);
        check("addr_hold", imem_addr, prev_addr);
      end
      prev_stall = imem_req && !imem_ready && !redirect_valid;
      prev_addr  = imem_addr;
      if (redirect_valid) begin
        sb_q.delete();
        exp_fetch_pc = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (instr_valid && instr_ready && exp_valid) begin
          e = sb_q.pop_front();
          check("pop_pc", instr_pc, e.pc);
          check("pop_data", instr_data, e.data);
          $display("pop pc=%h data=%h", instr_pc, instr_data);
        end
        if (imem_rvalid && mem_live && sb_q.size() != 0) begin
          e = sb_q.pop_back();
          e.arrived = 1'b1;
          sb_q.push_back(e);
        end
        if (imem_req && imem_ready) begin
          check("accept_addr", imem_addr, exp_fetch_pc);
          check("one_outstanding", {31'b0, mem_busy}, 32'd0);
          e.pc = exp_fetch_pc;
          e.data = mem_word(exp_fetch_pc);
          e.arrived = 1'b0;
          sb_q.push_back(e);
          exp_fetch_pc = exp_fetch_pc + 32'd4;
        end
      end
      if (imem_rvalid) mem_live = 1'b0;
      if (imem_req && imem_ready) begin
        accepts++;
        mem_busy = 1'b1;
        mem_live = !redirect_valid;
        mem_addr = imem_addr;
        mem_wait = $urandom_range(mem_lat_hi, mem_lat_lo);
      end
    end
  end

  task automatic step(input bit ir, input bit mr, input bit rd, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    instr_ready    = ir;
    imem_ready     = mr;
    redirect_valid = rd;
    redirect_pc    = rpc;
    imem_rvalid    = 1'b0;
    imem_rdata     = $urandom;
    if (mem_busy) begin
      mem_wait--;
      if (mem_wait <= 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_addr);
        mem_busy    = 1'b0;
      end
    end
  endtask

  task automatic wait_accept(input string name, input bit chk, input logic [31:0] req_addr);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      step(1'b1, 1'b1, 1'b0, '0);
      @(negedge clk);
      if (imem_req && imem_ready) begin
        got = 1'b1;
        if (chk) check(name, imem_addr, req_addr);
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s_timeout actual=no_accept required=accept", name);
    end
  endtask

  task automatic wait_pop(input string name, input logic [31:0] req_pc);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      step(1'b1, 1'b1, 1'b0, '0);
      @(negedge clk);
      if (instr_valid) begin
        got = 1'b1;
        check(name, instr_pc, req_pc);
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s_timeout actual=no_valid required=valid", name);
    end
  endtask

  task automatic check_reset();
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_data", instr_data, 32'd0);
    check("rst_pc", instr_pc, 32'd0);
    check("rst_fault", {31'b0, fetch_fault}, 32'd0);
  endtask

  // Releases reset with a stale response in the first cycle, which must be ignored.
  task automatic release_reset();
    @(posedge clk);
    #1;
    sb_q.delete();
    mem_busy = 1'b0;
    mem_live = 1'b0;
    prev_stall = 1'b0;
    exp_fetch_pc = RESET_PC;
    accepts = 0;
    rst = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    imem_ready = 1'b1;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    mon_en = 1'b1;
    step(1'b0, 1'b1, 1'b0, '0);
    @(negedge clk);
    check("req_after_reset", {31'b0, imem_req}, 32'd1);
    check("addr_after_reset", imem_addr, RESET_PC);
  endtask

  initial begin
    bit          rd;
    logic [31:0] rp;

    repeat (3) @(posedge clk);
    #1;
    check_reset();
    release_reset();

    // Decode stalled: exactly DEPTH reads fill the queue, then requests stop.
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, '0);
    @(negedge clk);
    check("full_accepts", accepts, DEPTH);
    check("full_no_req", {31'b0, imem_req}, 32'd0);
    check("full_valid", {31'b0, instr_valid}, 32'd1);
    wait_accept("resume_addr", 1'b1, 32'h00400008);

    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, '0);

    // Redirect while waiting on a slow response.
    mem_lat_lo = 3;
    mem_lat_hi = 3;
    wait_accept("pre_redirect", 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 32'h00400100);
    wait_accept("redirect_addr", 1'b1, 32'h00400100);
    wait_pop("redirect_pc", 32'h00400100);

    // Address wrap and misaligned redirect.
    mem_lat_lo = 1;
    mem_lat_hi = 1;
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    wait_accept("wrap0", 1'b1, 32'hFFFF_FFF8);
    wait_accept("wrap1", 1'b1, 32'hFFFF_FFFC);
    wait_accept("wrap2", 1'b1, 32'h0000_0000);
    step(1'b1, 1'b1, 1'b1, 32'h00400102);
    wait_accept("misaligned_addr", 1'b1, 32'h00400100);

    // Randomized traffic.
    mem_lat_lo = 1;
    mem_lat_hi = 4;
    for (int c = 0; c < 1500; c++) begin
      rd = ($urandom_range(99) < 3);
      rp = ($urandom_range(2) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                    : (RESET_PC + 32'($urandom_range(4095)));
      step($urandom_range(99) < 70, $urandom_range(99) < 60, rd, rp);
    end

    // Asynchronous reset mid-operation.
    @(posedge clk);
    #3;
    rst = 1'b0;
    mon_en = 1'b0;
    #1;
    check_reset();
    repeat (2) @(posedge clk);
    release_reset();

    for (int c = 0; c < 1500; c++) begin
      rd = ($urandom_range(99) < 3);
      rp = RESET_PC + 32'($urandom_range(1023));
      step($urandom_range(99) < 80, $urandom_range(99) < 70, rd, rp);
    end
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch front end for the single-cycle/multicycle RV32 core. Owns the fetch address (reset vector 0x00400000), issues word reads to instruction memory over a request/response handshake, and buffers returned instructions with their PCs in a small queue for the decode stage. A redirect from execute (branch/jump target) flushes the queue and any in-flight read.

## Interface
- ADDR_W, 32, fetch address and instruction width
- DEPTH, 2, instruction queue entries (power of two, ≥2)
- RESET_PC, 32'h00400000, first fetch address after reset
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- redirect_valid  in  1  load new fetch address this cycle
- redirect_pc  in  ADDR_W  new fetch address
- imem_req  out  1  read request valid
- imem_addr  out  ADDR_W  read address, word aligned
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  ADDR_W  read data
- instr_valid  out  1  queue head valid
- instr_data  out  ADDR_W  queue head instruction
- instr_pc  out  ADDR_W  PC of queue head
- instr_ready  in  1  decode consumes head this cycle
- fetch_fault  out  1  misaligned redirect detected (see Configuration)

## Operation
- Reset values: fetch_pc = RESET_PC, imem_req 0, imem_addr RESET_PC, instr_valid 0, instr_data 0, instr_pc 0, fetch_fault 0, queue empty, state IDLE.
- At most one outstanding read. Memory responses arrive in order, ≥1 cycle after acceptance.
- States: IDLE, REQ, WAIT, DRAIN, HALT (HALT only with macro).
- IDLE → REQ when queue count < DEPTH (slot reserved for the read).
- REQ: imem_req = 1, imem_addr = fetch_pc, held stable until imem_ready. On accept: fetch_pc += 4 (mod 2^ADDR_W, wraps 0xFFFFFFFC → 0), → WAIT.
- WAIT: on imem_rvalid push {imem_rdata, request PC} into queue; → REQ if space remains after push/pop this cycle, else IDLE.
- DRAIN: response of a flushed read is pending; on imem_rvalid discard data, → REQ.
- Pop: head removed when instr_valid && instr_ready. Push and pop same cycle allowed, including when full (count unchanged).
- Redirect (highest priority): queue emptied, fetch_pc ← redirect_pc, pop/push of that cycle ignored.
  - in IDLE or REQ without accept: → REQ with new address (unaccepted request may change address).
  - in REQ with imem_ready same cycle, or in WAIT without imem_rvalid: → DRAIN.
  - in WAIT with imem_rvalid same cycle: response discarded, → REQ.
  - in DRAIN: stays DRAIN, new fetch_pc retained.
- Asynchronous reset mid-operation returns all state to reset values immediately; any memory response that arrives after reset release without a request issued since then is ignored.

## Timing
- imem_req rises in the first cycle after rst deasserts.
- Redirect at cycle N → imem_req with redirect_pc at N+1.
- Request accepted at N, rvalid at N+k → instr_valid at N+k+1 (queue registered).
- Throughput with 1-cycle memory: one instruction per 2 cycles.
- All outputs registered; no combinational path from instr_ready or imem_rvalid to imem_req.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: redirect with redirect_pc[1:0] ≠ 0 flushes as normal, sets fetch_fault = 1, enters HALT (no requests; pending read drained first, then HALT). HALT exits only on an aligned redirect (fault cleared, → REQ) or reset.
- Not defined: redirect_pc[1:0] forced to 0, fetch_fault tied 0, HALT state absent.

## Test plan
- Reset release, imem_ready = 1, rvalid 1 cycle after accept, instr_ready = 1 -> imem_addr 0x00400000, 0x00400004, 0x00400008…; instr_pc matches each instr_data in order.
- instr_ready = 0 with DEPTH = 2 -> exactly 2 entries fill, imem_req stays 0; raise instr_ready -> fetching resumes at 0x00400008.
- imem_ready held 0 for 5 cycles -> imem_req/imem_addr stable all 5 cycles; single accept advances fetch_pc by 4.
- Redirect to 0x00400100 in WAIT -> queue empties, stale rdata discarded, next request address 0x00400100, next instr_pc 0x00400100.
- fetch_pc = 0xFFFFFFFC accepted -> next imem_addr 0x00000000.
- With FETCH_ALIGN_CHECK_EN, redirect to 0x00400102 -> fetch_fault = 1, no further imem_req; aligned redirect to 0x00400200 -> fault 0, request 0x00400200. Without macro -> request 0x00400100 issued.
